// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the iterative AES sequencer.
package aes_seq_pkg;
    localparam int NR     = 10;
    localparam int AES_W  = 128;
    localparam int KEYS_W = AES_W * NR;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} aes_ctrl_state_t;

    typedef struct packed {
        logic [AES_W-1:0]  msg;
        logic [KEYS_W-1:0] keys;
    } aes_job_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Round counter width; a single-cycle configuration still needs one bit.
    function automatic int k_w(input int cc);
        return (clog2(cc) > 0) ? clog2(cc) : 1;
    endfunction
endpackage

// File: rtl/aes_key_slice_mux.sv
// Picks key slice k out of the full round-key register; zero when disabled.
module aes_key_slice_mux
    import aes_seq_pkg::*;
#(
    parameter int CC = 2
) (
    input  logic [KEYS_W-1:0]    keys,
    input  logic [k_w(CC)-1:0]   k,
    input  logic                 en,
    output logic [KEYS_W/CC-1:0] key_slice
);
    localparam int KCW = k_w(CC);

    logic [CC-1:0][KEYS_W/CC-1:0] slices;
    assign slices = keys;

    always_comb begin
        key_slice = '0;
        for (int i = 0; i < CC; i++)
            if (en && k == KCW'(i)) key_slice = slices[i];
    end
endmodule

// File: rtl/aes_seq_ctrl.sv
// Host handshake and round sequencing for the aes_seq datapath.
module aes_seq_ctrl
    import aes_seq_pkg::*;
#(
    parameter int CC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_W-1:0]     in_msg,
    input  logic [KEYS_W-1:0]    in_keys,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_W-1:0]     out_data,
    output logic                 busy,
    output logic                 dp_load,
    output logic [AES_W-1:0]     dp_msg,
    output logic [KEYS_W/CC-1:0] dp_key,
    input  logic [AES_W-1:0]     dp_out
);
    localparam int KCW = k_w(CC);
    localparam logic [KCW-1:0] K_LAST = KCW'(CC - 1);

    aes_ctrl_state_t state, state_nxt;
    aes_job_t        job_q;
    logic [KCW-1:0]  k;
    logic            accept;
    logic            key_en;

    assign accept = in_valid & in_ready;
    assign dp_msg = job_q.msg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (k == K_LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == LOAD) || (state == RUN);
        out_valid = (state == DONE);
        key_en    = (state == RUN);
    end

    // dp_load comes from a flop so the datapath reset input never sees decode glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job_q    <= '0;
            k        <= '0;
            dp_load  <= 1'b0;
            out_data <= '0;
        end else begin
            if (accept) job_q <= '{msg: in_msg, keys: in_keys};
            dp_load <= (state_nxt == LOAD);
            if (state == LOAD)
                k <= '0;
            else if (state == RUN && k != K_LAST)
                k <= k + 1'b1;
            // Datapath output is combinational from its state, so it is final on the last slice.
            if (state == RUN && k == K_LAST) out_data <= dp_out;
        end
    end

    aes_key_slice_mux #(.CC(CC)) u_key_mux (
        .keys      (job_q.keys),
        .k         (k),
        .en        (key_en),
        .key_slice (dp_key)
    );
endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Bench for aes_seq_ctrl: four instances (CC=1,2,5,10) each driving a stand-in datapath.
module tb_aes_seq_ctrl;
    import aes_seq_pkg::*;

    logic clk;
    logic rst;
    logic              in_valid[4], in_ready[4], out_valid[4], out_ready[4], busy[4], dp_load[4];
    logic [AES_W-1:0]  in_msg[4], out_data[4], dp_msg[4], dp_out[4];
    logic [KEYS_W-1:0] in_keys[4], dp_key[4];
    int vectors = 0;
    int miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cc_of(input int i);
        case (i)
            0: return 1;
            1: return 2;
            2: return 5;
            default: return 10;
        endcase
    endfunction

    // Stand-in round step, used by both the fake datapath and the reference.
    function automatic logic [AES_W-1:0] rstep(input logic [AES_W-1:0] x, input logic [AES_W-1:0] rk);
        return {x[AES_W-2:0], x[AES_W-1]} ^ rk;
    endfunction

    // Reference: all NR round keys applied in order 0..NR-1, independent of CC.
    function automatic logic [AES_W-1:0] ref_model(input logic [AES_W-1:0] msg, input logic [KEYS_W-1:0] keys);
        logic [AES_W-1:0] x;
        x = msg;
        for (int j = 0; j < NR; j++) x = rstep(x, keys[AES_W*j +: AES_W]);
        return x;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : lane
        localparam int C  = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
        localparam int KW = KEYS_W / C;
        logic [KW-1:0]    key_w;
        logic [AES_W-1:0] st, o;

        aes_seq_ctrl #(.CC(C)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_msg    (in_msg[g]),
            .in_keys   (in_keys[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g]),
            .dp_load   (dp_load[g]),
            .dp_msg    (dp_msg[g]),
            .dp_key    (key_w),
            .dp_out    (dp_out[g])
        );

        // Fake datapath: NR/C rounds per clock, output combinational from state.
        always_comb begin
            o = st;
            for (int j = 0; j < NR / C; j++) o = rstep(o, key_w[AES_W*j +: AES_W]);
        end
        always @(posedge clk) st <= dp_load[g] ? dp_msg[g] : o;
        assign dp_out[g] = o;
        assign dp_key[g] = KEYS_W'(key_w);
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [AES_W-1:0] obs, input logic [AES_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic key_chk(input string tag, input int i, input logic [KEYS_W-1:0] exp);
        for (int c = 0; c < NR; c++) chkw(tag, dp_key[i][AES_W*c +: AES_W], exp[AES_W*c +: AES_W]);
    endtask

    task automatic idle_chk(input int i);
        chk1("idle_in_ready", in_ready[i], 1'b1);
        chk1("idle_out_valid", out_valid[i], 1'b0);
        chk1("idle_busy", busy[i], 1'b0);
        chk1("idle_dp_load", dp_load[i], 1'b0);
        key_chk("idle_dp_key", i, '0);
    endtask

    // Starts at a negedge with the lane idle; ends at the negedge after the DONE handshake.
    task automatic run_job(input int i, input logic [AES_W-1:0] msg, input logic [KEYS_W-1:0] keys,
                           input int delay, input bit hold_valid,
                           input logic [AES_W-1:0] nmsg, input logic [KEYS_W-1:0] nkeys);
        int kw;
        logic [KEYS_W-1:0] mask, expk;
        logic [AES_W-1:0] exp;
        kw   = KEYS_W / cc_of(i);
        mask = {KEYS_W{1'b1}} >> (KEYS_W - kw);
        exp  = ref_model(msg, keys);
        chk1("accept_in_ready", in_ready[i], 1'b1);
        in_valid[i] = 1'b1; in_msg[i] = msg; in_keys[i] = keys;
        @(negedge clk);
        if (hold_valid) begin in_msg[i] = nmsg; in_keys[i] = nkeys; end
        else in_valid[i] = 1'b0;
        chk1("load_dp_load", dp_load[i], 1'b1);
        chk1("load_busy", busy[i], 1'b1);
        chk1("load_in_ready", in_ready[i], 1'b0);
        key_chk("load_dp_key", i, '0);
        for (int k = 0; k < cc_of(i); k++) begin
            @(negedge clk);
            chk1("run_dp_load", dp_load[i], 1'b0);
            chk1("run_busy", busy[i], 1'b1);
            chk1("run_out_valid", out_valid[i], 1'b0);
            expk = (keys >> (kw * k)) & mask;
            key_chk("run_dp_key", i, expk);
        end
        @(negedge clk);
        chk1("done_out_valid", out_valid[i], 1'b1);
        chk1("done_busy", busy[i], 1'b0);
        chk1("done_in_ready", in_ready[i], 1'b0);
        chkw("done_out_data", out_data[i], exp);
        key_chk("done_dp_key", i, '0);
        repeat (delay) begin
            @(negedge clk);
            chk1("bp_out_valid", out_valid[i], 1'b1);
            chk1("bp_in_ready", in_ready[i], 1'b0);
            chk1("bp_busy", busy[i], 1'b0);
            chkw("bp_out_data", out_data[i], exp);
        end
        out_ready[i] = 1'b1;
        @(negedge clk);
        out_ready[i] = 1'b0;
        chk1("hs_out_valid", out_valid[i], 1'b0);
        chk1("hs_in_ready", in_ready[i], 1'b1);
    endtask

    task automatic rand_job(output logic [AES_W-1:0] msg, output logic [KEYS_W-1:0] keys);
        for (int c = 0; c < 4; c++) msg[32*c +: 32] = $urandom;
        for (int c = 0; c < KEYS_W / 32; c++) keys[32*c +: 32] = $urandom;
    endtask

    initial begin
        logic [AES_W-1:0]  m, m2;
        logic [KEYS_W-1:0] kk, kk2;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_msg[i] = '0; in_keys[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            idle_chk(i);
            chkw("reset_out_data", out_data[i], '0);
        end

        // FIPS-197 plaintext with a stand-in key list on CC=2.
        m = 128'h00112233445566778899aabbccddeeff;
        for (int j = 0; j < NR; j++) kk[AES_W*j +: AES_W] = 128'h000102030405060708090a0b0c0d0e0f ^ AES_W'(j);
        run_job(1, m, kk, 0, 1'b0, '0, '0);

        // Backpressure with in_valid held high; the second job follows the handshake.
        rand_job(m, kk);
        rand_job(m2, kk2);
        run_job(1, m, kk, 10, 1'b1, m2, kk2);
        run_job(1, m2, kk2, 0, 1'b0, '0, '0);

        // Reset while dp_load is high.
        in_valid[1] = 1'b1;
        @(negedge clk);
        in_valid[1] = 1'b0;
        chk1("rload_dp_load_pre", dp_load[1], 1'b1);
        rst = 1'b1;
        #1;
        chk1("rload_dp_load", dp_load[1], 1'b0);
        chk1("rload_busy", busy[1], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        idle_chk(1);

        // Reset at k=1 on CC=5.
        rand_job(m, kk);
        in_valid[2] = 1'b1; in_msg[2] = m; in_keys[2] = kk;
        @(negedge clk);
        in_valid[2] = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rrun_busy_pre", busy[2], 1'b1);
        rst = 1'b1;
        #1;
        chk1("rrun_busy", busy[2], 1'b0);
        chk1("rrun_in_ready", in_ready[2], 1'b1);
        chk1("rrun_dp_load", dp_load[2], 1'b0);
        key_chk("rrun_dp_key", 2, '0);
        chkw("rrun_out_data", out_data[2], '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk1("rrun_no_out_valid", out_valid[2], 1'b0);
            chk1("rrun_idle_busy", busy[2], 1'b0);
        end
        rand_job(m, kk);
        run_job(2, m, kk, 1, 1'b0, '0, '0);

        // Random sweep over all CC values.
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 50; n++) begin
                rand_job(m, kk);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                run_job(i, m, kk, int'($urandom_range(0, 3)), 1'b0, '0, '0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
